matrix_cmd_issuer: RTL

Command-side driver for the matrix stack controller. It accepts GL matrix commands from the command decoder over a valid/ready stream and buffers multi-beat payloads (4 rows of 128 bits). It replays them on the stack controller's pulse/row protocol: `load_id_en`, `load_en` plus 4 back-to-back rows, `pop_en`, and `write_en` plus 4 parallel rows. It also tracks per-mode stack occupancy so that overflow and underflow are rejected before reaching the stack.

---
 rtl/matrix_pkg.sv | 33 +++
 rtl/row_buf4.sv | 26 ++
 rtl/matrix_cmd_issuer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared constants and types for the matrix command issuer.
package matrix_pkg;

    localparam int ROW_W = 128;

    // Command opcodes as carried on cmd_op; 6 and 7 are reserved.
    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_MODE    = 3'd1;
    localparam logic [2:0] OP_LOAD_ID = 3'd2;
    localparam logic [2:0] OP_LOAD    = 3'd3;
    localparam logic [2:0] OP_POP     = 3'd4;
    localparam logic [2:0] OP_WRITE   = 3'd5;

    // Bit positions inside the sticky err vector.
    localparam int ERR_PROTO = 0;
    localparam int ERR_OVF   = 1;
    localparam int ERR_UNF   = 2;

    // Identity matrix rows, element 0 in the top 32 bits (1.0f = 0x3f800000).
    localparam logic [ROW_W-1:0] IDENT_ROW0 = {32'h3f80_0000, 96'h0};
    localparam logic [ROW_W-1:0] IDENT_ROW1 = {32'h0, 32'h3f80_0000, 64'h0};
    localparam logic [ROW_W-1:0] IDENT_ROW2 = {64'h0, 32'h3f80_0000, 32'h0};
    localparam logic [ROW_W-1:0] IDENT_ROW3 = {96'h0, 32'h3f80_0000};

    typedef enum logic [2:0] {
        ST_COLLECT = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_STREAM1 = 3'd2,
        ST_STREAM2 = 3'd3,
        ST_STREAM3 = 3'd4
    } state_t;

endpackage

// File: rtl/row_buf4.sv
// Four-row payload buffer: write one row by index, read all rows in parallel.
module row_buf4 #(
    parameter int ROW_W = matrix_pkg::ROW_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [1:0]            wr_idx,
    input  logic [ROW_W-1:0]      wr_data,
    output logic [3:0][ROW_W-1:0] rows
);

    // Clear wipes every row; a same-cycle write still lands in its slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rows <= '0;
        end else begin
            if (clr)
                rows <= '0;
            if (wr_en)
                rows[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/matrix_cmd_issuer.sv
// Buffers GL matrix commands and replays them as stack-controller pulses,
// rejecting stack overflow/underflow before they reach the stack.
module matrix_cmd_issuer #(
    parameter int ROW_W       = matrix_pkg::ROW_W,
    parameter int STACK_SLOTS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [ROW_W-1:0] cmd_data,
    input  logic             fifo_full,
    input  logic             err_clr,
    output logic             matrix_mode,
    output logic             load_id_en,
    output logic             load_en,
    output logic             pop_en,
    output logic             write_en,
    output logic [ROW_W-1:0] data_in,
    output logic [ROW_W-1:0] write_in_0,
    output logic [ROW_W-1:0] write_in_1,
    output logic [ROW_W-1:0] write_in_2,
    output logic [ROW_W-1:0] write_in_3,
    output logic [2:0]       err,
    output logic             busy
);
    import matrix_pkg::*;

    localparam int               LVL_W   = (STACK_SLOTS > 1) ? $clog2(STACK_SLOTS) : 1;
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(STACK_SLOTS - 1);

    state_t                  state, state_nxt;
    logic [1:0]              row_cnt, row_cnt_nxt, fresh_cnt;
    logic [2:0]              pend_op, pend_op_nxt;
    logic [1:0][LVL_W-1:0]   level, level_nxt;
    logic                    mode_nxt;
    logic [2:0]              err_nxt;
    logic                    load_id_nxt, load_nxt, pop_nxt, write_nxt;
    logic [ROW_W-1:0]        data_in_nxt;
    logic [3:0][ROW_W-1:0]   wr_rows, wr_rows_nxt;
    logic [3:0][ROW_W-1:0]   rows;
    logic                    buf_wr, buf_clr;
    logic [1:0]              buf_idx;
    logic                    accept;

    // Ready is held low while reset is asserted so nothing is taken mid-reset.
    assign cmd_ready  = (state == ST_COLLECT) & reset;
    assign accept     = cmd_valid & cmd_ready;
    assign busy       = (state != ST_COLLECT) || (row_cnt != 2'd0);
    assign write_in_0 = wr_rows[0];
    assign write_in_1 = wr_rows[1];
    assign write_in_2 = wr_rows[2];
    assign write_in_3 = wr_rows[3];

    row_buf4 #(.ROW_W(ROW_W)) u_buf (
        .clk     (clk),
        .reset   (reset),
        .clr     (buf_clr),
        .wr_en   (buf_wr),
        .wr_idx  (buf_idx),
        .wr_data (cmd_data),
        .rows    (rows)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_COLLECT;
        else
            state <= state_nxt;
    end

    // Next-state, datapath updates and registered pulses.
    always_comb begin
        state_nxt   = state;
        row_cnt_nxt = row_cnt;
        fresh_cnt   = row_cnt;
        pend_op_nxt = pend_op;
        level_nxt   = level;
        mode_nxt    = matrix_mode;
        err_nxt     = err_clr ? 3'b000 : err;
        load_id_nxt = 1'b0;
        load_nxt    = 1'b0;
        pop_nxt     = 1'b0;
        write_nxt   = 1'b0;
        data_in_nxt = data_in;
        wr_rows_nxt = wr_rows;
        buf_wr      = 1'b0;
        buf_clr     = 1'b0;
        buf_idx     = row_cnt;

        case (state)
            ST_COLLECT: begin
                if (accept) begin
                    // A different op in the middle of a burst abandons the burst.
                    if (row_cnt != 2'd0 && cmd_op != pend_op) begin
                        err_nxt[ERR_PROTO] = 1'b1;
                        buf_clr            = 1'b1;
                        fresh_cnt          = 2'd0;
                    end
                    row_cnt_nxt = fresh_cnt;
                    case (cmd_op)
                        OP_NOP: ;
                        OP_MODE: mode_nxt = cmd_data[0];
                        OP_LOAD_ID, OP_POP: begin
                            pend_op_nxt = cmd_op;
                            state_nxt   = ST_ISSUE;
                        end
                        OP_LOAD, OP_WRITE: begin
                            buf_wr      = 1'b1;
                            buf_idx     = fresh_cnt;
                            pend_op_nxt = cmd_op;
                            row_cnt_nxt = fresh_cnt + 2'd1;
                            if (fresh_cnt == 2'd3)
                                state_nxt = ST_ISSUE;
                        end
                        default: err_nxt[ERR_PROTO] = 1'b1;
                    endcase
                end
            end

            ST_ISSUE: begin
                if (!fifo_full) begin
                    state_nxt = ST_COLLECT;
                    case (pend_op)
                        OP_LOAD_ID: load_id_nxt = 1'b1;
                        OP_LOAD: begin
                            if (level[matrix_mode] == LVL_MAX) begin
                                err_nxt[ERR_OVF] = 1'b1;
                            end else begin
                                load_nxt               = 1'b1;
                                data_in_nxt            = rows[0];
                                level_nxt[matrix_mode] = level[matrix_mode] + LVL_W'(1);
                                state_nxt              = ST_STREAM1;
                            end
                        end
                        OP_POP: begin
                            if (level[matrix_mode] == '0) begin
                                err_nxt[ERR_UNF] = 1'b1;
                            end else begin
                                pop_nxt                = 1'b1;
                                level_nxt[matrix_mode] = level[matrix_mode] - LVL_W'(1);
                            end
                        end
                        OP_WRITE: begin
                            write_nxt   = 1'b1;
                            wr_rows_nxt = rows;
                        end
                        default: ;
                    endcase
                end
            end

            // Rows 1..3 follow load_en unconditionally; the consumer cannot stall.
            ST_STREAM1: begin
                data_in_nxt = rows[1];
                state_nxt   = ST_STREAM2;
            end
            ST_STREAM2: begin
                data_in_nxt = rows[2];
                state_nxt   = ST_STREAM3;
            end
            ST_STREAM3: begin
                data_in_nxt = rows[3];
                state_nxt   = ST_COLLECT;
            end
            default: state_nxt = ST_COLLECT;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_cnt     <= 2'd0;
            pend_op     <= OP_NOP;
            level       <= '0;
            matrix_mode <= 1'b0;
            err         <= 3'b000;
            load_id_en  <= 1'b0;
            load_en     <= 1'b0;
            pop_en      <= 1'b0;
            write_en    <= 1'b0;
            data_in     <= '0;
            wr_rows     <= '0;
        end else begin
            row_cnt     <= row_cnt_nxt;
            pend_op     <= pend_op_nxt;
            level       <= level_nxt;
            matrix_mode <= mode_nxt;
            err         <= err_nxt;
            load_id_en  <= load_id_nxt;
            load_en     <= load_nxt;
            pop_en      <= pop_nxt;
            write_en    <= write_nxt;
            data_in     <= data_in_nxt;
            wr_rows     <= wr_rows_nxt;
        end
    end

endmodule
